clk_rate_seq: RTL and testbench

CLK_RATE_SEQ -- requirements
Module: clk_rate_seq

---
 rtl/clk_rate_seq.sv | 146 ++++++++++++++
 tb/tb_clk_rate_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/clk_rate_seq.sv
// clk_rate_seq
//   Generates a burst of Burst_Len clock periods on Clk_O at one of two rates.
//   Each phase lasts H+1 cycles of Clk, where H is HALF_FAST or HALF_SLOW
//   depending on Mode_Cur. A falling edge of Clk_O marks a period boundary.
//   Rate changes and burst termination happen only on those boundaries, so
//   Clk_O never shows a truncated high phase.
//
// Ports
//   Clk        in   system clock, rising edge
//   Rst_n      in   asynchronous active-low reset
//   Start      in   begin a burst (accepted in IDLE only)
//   Stop       in   request early termination of the running burst
//   Mode_Req   in   requested rate: 0 slow, 1 fast
//   Burst_Len  in   [15:0] number of periods, latched on Start
//   Clk_O      out  generated clock
//   Mode_Cur   out  rate currently applied
//   Busy       out  high while a burst runs
//   Done       out  one-cycle pulse on normal completion
//   Period_Cnt out  [15:0] completed periods in current/last burst
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | Clk_O low, counter cleared, waiting for Start
// RUN    | toggling Clk_O; r_stopping marks a pending Stop while high
module clk_rate_seq #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned HALF_SLOW = 12500000,
  parameter int unsigned HALF_FAST = 6250000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start,
  input  logic        Stop,
  input  logic        Mode_Req,
  input  logic [15:0] Burst_Len,
  output logic        Clk_O,
  output logic        Mode_Cur,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] Period_Cnt
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [CNT_W-1:0] H_SLOW = CNT_W'(HALF_SLOW);
  localparam logic [CNT_W-1:0] H_FAST = CNT_W'(HALF_FAST);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_clk;
  logic             r_mode;
  logic             r_busy;
  logic             r_done;
  logic [15:0]      r_pcnt;
  logic [15:0]      r_len;
  logic             r_stopping;
  logic             r_armed;

  logic [CNT_W-1:0] w_half;
  logic             w_tc;
  logic [15:0]      w_pcnt_nxt;

  assign w_half     = r_mode ? H_FAST : H_SLOW;
  // Greater-or-equal keeps the counter from running past the terminal count
  // should H ever shrink underneath a partially counted phase.
  assign w_tc       = (r_cnt >= w_half);
  assign w_pcnt_nxt = r_pcnt + 16'd1;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_clk      <= 1'b0;
      r_mode     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pcnt     <= 16'd0;
      r_len      <= 16'd0;
      r_stopping <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      // r_armed blocks Start on the first edge out of reset.
      r_armed <= 1'b1;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_clk      <= 1'b0;
          r_cnt      <= '0;
          r_stopping <= 1'b0;
          r_busy     <= 1'b0;
          if (r_armed && Start) begin
            r_pcnt <= 16'd0;
            if (Burst_Len != 16'd0) begin
              r_len   <= Burst_Len;
              r_mode  <= Mode_Req;
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        default: begin
          if (w_tc) begin
            r_cnt <= '0;
            r_clk <= ~r_clk;
            if (r_clk) begin
              // Falling toggle: period boundary.
              r_pcnt <= w_pcnt_nxt;
              r_mode <= Mode_Req;
              if (w_pcnt_nxt == r_len) begin
                // Completion wins over a simultaneous or pending Stop.
                r_done  <= 1'b1;
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end else if (r_stopping || Stop) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          // Stop while low: leave now, suppressing any rising toggle.
          // Stop while high: remember it and leave at the falling toggle.
          if (Stop && !r_clk) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_clk   <= 1'b0;
            r_cnt   <= '0;
          end else if (Stop) begin
            r_stopping <= 1'b1;
          end
        end
      endcase
    end
  end

  assign Clk_O      = r_clk;
  assign Mode_Cur   = r_mode;
  assign Busy       = r_busy;
  assign Done       = r_done;
  assign Period_Cnt = r_pcnt;

endmodule

// File: tb/tb_clk_rate_seq.sv
module tb_clk_rate_seq;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic        Start = 1'b0;
  logic        Stop = 1'b0;
  logic        Mode_Req = 1'b0;
  logic [15:0] Burst_Len = 16'd0;
  logic        Clk_O;
  logic        Mode_Cur;
  logic        Busy;
  logic        Done;
  logic [15:0] Period_Cnt;

  int n_vec = 0;
  int n_err = 0;

  clk_rate_seq #(.CNT_W(32), .HALF_SLOW(4), .HALF_FAST(2)) u_dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Start      (Start),
    .Stop       (Stop),
    .Mode_Req   (Mode_Req),
    .Burst_Len  (Burst_Len),
    .Clk_O      (Clk_O),
    .Mode_Cur   (Mode_Cur),
    .Busy       (Busy),
    .Done       (Done),
    .Period_Cnt (Period_Cnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Start is sampled on the edge inside this task: that is edge 0.
  task automatic start_burst(input logic [15:0] len, input logic mode);
    Burst_Len = len;
    Mode_Req  = mode;
    Start     = 1'b1;
    tick();
    Start     = 1'b0;
  endtask

  initial begin
    // ---------------- reset values ----------------
    #1 Rst_n = 1'b0;
    #2;
    chk("rst_clk",  32'(Clk_O), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_pcnt", 32'(Period_Cnt), 32'd0);
    chk("rst_mode", 32'(Mode_Cur), 32'd0);

    // ---------------- first edge after reset ignores Start ----------------
    Burst_Len = 16'd3;
    Mode_Req  = 1'b0;
    Start     = 1'b1;
    @(negedge Clk);
    Rst_n = 1'b1;
    tick();
    chk("first_edge_busy", 32'(Busy), 32'd0);
    tick();                                   // edge 0 of normal slow burst
    Start = 1'b0;
    chk("s1_e0_busy", 32'(Busy), 32'd1);
    chk("s1_e0_pcnt", 32'(Period_Cnt), 32'd0);

    // ---------------- normal slow burst, Start while busy at edge 12 -----
    for (int e = 1; e <= 32; e++) begin
      tick();
      chk("s1_clk",  32'(Clk_O), 32'((e >= 5 && e < 10) || (e >= 15 && e < 20) || (e >= 25 && e < 30)));
      chk("s1_done", 32'(Done), 32'(e == 30));
      chk("s1_busy", 32'(Busy), 32'(e < 30));
      if (e == 11) begin Start = 1'b1; Burst_Len = 16'd7; end
      if (e == 12) Start = 1'b0;
    end
    chk("s1_pcnt", 32'(Period_Cnt), 32'd3);

    // ---------------- mode switch mid-period ----------------
    start_burst(16'd3, 1'b0);
    for (int e = 1; e <= 24; e++) begin
      tick();
      chk("s2_clk",  32'(Clk_O), 32'((e >= 5 && e < 10) || (e >= 13 && e < 16) || (e >= 19 && e < 22)));
      chk("s2_mode", 32'(Mode_Cur), 32'(e >= 10));
      chk("s2_done", 32'(Done), 32'(e == 22));
      if (e == 6) Mode_Req = 1'b1;            // sampled from edge 7 on
    end
    chk("s2_pcnt", 32'(Period_Cnt), 32'd3);

    // ---------------- Stop during high phase ----------------
    start_burst(16'd3, 1'b0);
    chk("s3_mode_load", 32'(Mode_Cur), 32'd0);
    for (int e = 1; e <= 14; e++) begin
      tick();
      chk("s3_clk",  32'(Clk_O), 32'(e >= 5 && e < 10));
      chk("s3_busy", 32'(Busy), 32'(e < 10));
      chk("s3_done", 32'(Done), 32'd0);
      Stop = (e == 6);                        // sampled at edge 7
    end
    chk("s3_pcnt", 32'(Period_Cnt), 32'd1);

    // ---------------- Stop during low phase ----------------
    start_burst(16'd3, 1'b0);
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk("s3b_clk",  32'(Clk_O), 32'd0);
      chk("s3b_busy", 32'(Busy), 32'(e < 3));
      chk("s3b_done", 32'(Done), 32'd0);
      Stop = (e == 2);                        // sampled at edge 3
    end
    chk("s3b_pcnt", 32'(Period_Cnt), 32'd0);

    // ---------------- Stop on final boundary ----------------
    start_burst(16'd1, 1'b0);
    for (int e = 1; e <= 12; e++) begin
      tick();
      chk("s4_clk",  32'(Clk_O), 32'(e >= 5 && e < 10));
      chk("s4_done", 32'(Done), 32'(e == 10));
      chk("s4_busy", 32'(Busy), 32'(e < 10));
      Stop = (e == 9);                        // sampled at edge 10
    end
    chk("s4_pcnt", 32'(Period_Cnt), 32'd1);

    // ---------------- zero length ----------------
    start_burst(16'd0, 1'b0);
    chk("s5_done", 32'(Done), 32'd1);
    chk("s5_busy", 32'(Busy), 32'd0);
    chk("s5_pcnt", 32'(Period_Cnt), 32'd0);
    tick();
    chk("s5_done_off", 32'(Done), 32'd0);
    chk("s5_busy_off", 32'(Busy), 32'd0);

    // ---------------- reset mid-burst (fast, high phase at edge 16) -----
    start_burst(16'd3, 1'b1);
    for (int e = 1; e <= 16; e++) tick();
    chk("s6_pre_clk",  32'(Clk_O), 32'd1);
    chk("s6_pre_pcnt", 32'(Period_Cnt), 32'd2);
    chk("s6_pre_mode", 32'(Mode_Cur), 32'd1);
    #2 Rst_n = 1'b0;
    #1;
    chk("s6_clk",  32'(Clk_O), 32'd0);
    chk("s6_busy", 32'(Busy), 32'd0);
    chk("s6_pcnt", 32'(Period_Cnt), 32'd0);
    chk("s6_mode", 32'(Mode_Cur), 32'd0);
    for (int e = 0; e < 3; e++) begin
      tick();
      chk("s6_done", 32'(Done), 32'd0);
    end

    // ---------------- restart after reset ----------------
    Burst_Len = 16'd1;
    Mode_Req  = 1'b0;
    Start     = 1'b1;
    @(negedge Clk);
    Rst_n = 1'b1;
    tick();
    chk("s7_first_edge_busy", 32'(Busy), 32'd0);
    tick();
    Start = 1'b0;
    chk("s7_busy", 32'(Busy), 32'd1);
    for (int e = 1; e <= 11; e++) begin
      tick();
      chk("s7_done", 32'(Done), 32'(e == 10));
    end
    chk("s7_pcnt", 32'(Period_Cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
